team_06_i2s_rx: RTL and testbench
=================================

// Module: team_06_i2s_rx
// PURPOSE
//  I2S receiver: first stage of the team_06 audio chain, directly upstream of the tremolo/effects stages.
//  Synchronises external I2S SCK/WS/SD into clk, deserialises one channel MSB-first, and keeps its top 8 bits.
//  Converts two's-complement to offset-binary (128 = silence) and presents audio_out with a 1-cycle sample_valid strobe.
// PARAMETERS
//  CHANNEL        0   captured channel: 0 = left (WS low), 1 = right (WS high)
//  MAX_SLOT_BITS  32  longest legal slot in SCK periods; exceeding it is a frame error
// PORTS
//  clk           in   1  system clock; all logic on posedge clk
//  rst           in   1  reset, asynchronous, active-high
//  en            in   1  receiver enable; low forces IDLE
//  i2s_sck       in   1  external bit clock, async to clk, period >= 8 clk cycles
//  i2s_ws        in   1  external word select, async
//  i2s_sd        in   1  external serial data, async
//  audio_out     out  8  latest sample, offset-binary, held between updates
//  sample_valid  out  1  1-cycle pulse, high in the cycle audio_out takes a new value
//  frame_err     out  1  1-cycle pulse on a short or overlong slot
// BEHAVIOUR
//  Reset: audio_out=8'd128, sample_valid=0, frame_err=0, state=IDLE, bit_cnt=0, shift=0, ws_prev=0, sync flops=0.
//  Sync: SCK, WS, SD each pass 2 flops. sck_rise = sck_s1 & ~sck_s2. All WS/SD sampling happens only in cycles with sck_rise.
//  ws_edge = sck_rise & (ws_s != ws_prev). ws_prev updates on every sck_rise.
//  Each slot's MSB is the bit sampled on the first sck_rise after ws_edge (standard I2S one-bit delay).
//  The bit sampled on the ws_edge rise is the previous slot's LSB and is discarded.
//  bit_cnt: 6-bit counter. Cleared on ws_edge, +1 on every other sck_rise, saturates at MAX_SLOT_BITS.
//  FSM:
//   IDLE  : wait for ws_edge. On ws_edge: go WAIT if ws_s==CHANNEL, else SKIP.
//   WAIT  : consume the delay bit. On the next sck_rise go SHIFT with bit_cnt=0.
//   SHIFT : on each sck_rise, shift = {shift[6:0], sd_s} and bit_cnt++. When the 8th bit is captured (bit_cnt==7 at the rise), go SKIP.
//           Next cycle: audio_out={~shift[7],shift[6:0]}, sample_valid=1.
//   SKIP  : ignore the remaining bits. On ws_edge: go WAIT if ws_s==CHANNEL, else stay SKIP.
//  Latency: sample_valid asserts exactly 1 clk after the sck_rise that samples the 8th MSB. Sync adds 2-3 clk from the pin edge.
//  Short slot: ws_edge while in SHIFT (fewer than 8 bits captured) -> frame_err pulse, partial word dropped, audio_out unchanged.
//   The new slot is then handled per the IDLE ws_edge rule in the same cycle.
//  Overlong slot: bit_cnt reaches MAX_SLOT_BITS with no ws_edge -> frame_err pulse, go IDLE.
//  ws_edge coincident with the 8th bit: impossible by construction (ws_edge clears bit_cnt). It is treated as a short slot.
//  en low: state goes IDLE next cycle, shift and bit_cnt clear, no strobes, audio_out holds.
//   Sync flops and ws_prev keep running. On en rising, capture resumes at the next ws_edge.
//  rst mid-slot: all state clears immediately (async). The first sample after release requires a full ws_edge.
//  sample_valid and frame_err are never high in the same cycle.
// STRUCTURE
//  team_06_audio_pkg: state enum i2s_rx_state_t {IDLE,WAIT,SHIFT,SKIP}, localparam AUDIO_MIDSCALE=8'd128, AUDIO_W=8.
//  Sub-module team_06_sync2 (2-flop synchroniser with async reset), instantiated 3x for SCK, WS, SD.
//  One always_ff for state/counters/outputs, one always_comb for next-state.
// TESTING
//  Reset: assert rst mid-run -> audio_out==128, strobes 0 the same cycle, with no clk edge needed.
//  Left word 0x7F... (CHANNEL=0, 32-bit slots, SCK=clk/16) -> audio_out==8'hFF, one sample_valid per frame.
//   0x80... -> 8'h00. 0x00... -> 8'h80.
//  CHANNEL=1 with left=0x12..., right=0xC3... -> audio_out==8'h43 only; left data never appears.
//  Short slot: WS toggles after 5 bits -> one frame_err, audio_out holds its previous value, next full frame decodes correctly.
//  Stuck WS for 40 SCK periods -> frame_err once at bit 32, FSM IDLE. Recovery on the next WS edge.
//  en low for 3 frames -> no sample_valid, audio_out held. en high -> first strobe after the next left-slot start, value correct.

Source files
------------

// File: rtl/team_06_audio_pkg.sv
// Shared types and constants for the team_06 audio chain.
package team_06_audio_pkg;

  localparam int AUDIO_W = 8;
  localparam logic [AUDIO_W-1:0] AUDIO_MIDSCALE = 8'd128;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SHIFT,
    SKIP
  } i2s_rx_state_t;

  // Two's-complement to offset-binary: flipping the sign bit puts silence at mid-scale.
  function automatic logic [AUDIO_W-1:0] to_offset_binary(input logic [AUDIO_W-1:0] s);
    return {~s[AUDIO_W-1], s[AUDIO_W-2:0]};
  endfunction

endpackage

// File: rtl/team_06_sync2.sv
// Two-flop synchroniser for one asynchronous input bit.
module team_06_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // The first flop may go metastable; only the second flop's output is used.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/team_06_i2s_rx.sv
// I2S receiver: captures the top 8 bits of one channel and emits them as offset-binary samples.
module team_06_i2s_rx
  import team_06_audio_pkg::*;
#(
  parameter int unsigned CHANNEL       = 0,
  parameter int unsigned MAX_SLOT_BITS = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               i2s_sck,
  input  logic               i2s_ws,
  input  logic               i2s_sd,
  output logic [AUDIO_W-1:0] audio_out,
  output logic               sample_valid,
  output logic               frame_err
);

  localparam logic       CHAN_WS = (CHANNEL != 0);
  localparam logic [5:0] MAX_CNT = 6'(MAX_SLOT_BITS);

  logic sck_s1, ws_s, sd_s;
  logic sck_rise, ws_edge, ws_match;

  i2s_rx_state_t      state_q, state_d;
  logic               sck_s2_q, sck_s2_d;
  logic               ws_prev_q, ws_prev_d;
  logic [5:0]         bit_cnt_q, bit_cnt_d;
  logic [AUDIO_W-1:0] shift_q, shift_d;
  logic [AUDIO_W-1:0] audio_q, audio_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  team_06_sync2 u_sync_sck (.clk(clk), .rst(rst), .d(i2s_sck), .q(sck_s1));
  team_06_sync2 u_sync_ws  (.clk(clk), .rst(rst), .d(i2s_ws),  .q(ws_s));
  team_06_sync2 u_sync_sd  (.clk(clk), .rst(rst), .d(i2s_sd),  .q(sd_s));

  assign sck_rise = sck_s1 & ~sck_s2_q;
  assign ws_edge  = sck_rise & (ws_s != ws_prev_q);
  assign ws_match = (ws_s == CHAN_WS);

  // State register: every flop of the receiver, outputs included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sck_s2_q  <= 1'b0;
      ws_prev_q <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      audio_q   <= AUDIO_MIDSCALE;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sck_s2_q  <= sck_s2_d;
      ws_prev_q <= ws_prev_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      audio_q   <= audio_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // Next-state: bit counting, slot tracking, deserialisation and strobe generation.
  // WAIT spans the one-bit I2S delay; the rise that leaves it samples the MSB, so the
  // captured bit index always equals bit_cnt at its rise and the 8th bit lands on bit_cnt==7.
  always_comb begin
    sck_s2_d  = sck_s1;
    ws_prev_d = sck_rise ? ws_s : ws_prev_q;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    audio_d   = audio_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    if (!en) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (sck_rise) begin
      if (ws_edge) begin
        bit_cnt_d = '0;
      end else if (bit_cnt_q != MAX_CNT) begin
        bit_cnt_d = bit_cnt_q + 6'd1;
      end

      if (ws_edge) begin
        // A new slot always restarts the FSM; an unfinished word is a short slot.
        if (state_q == SHIFT) begin
          err_d = 1'b1;
        end
        state_d = ws_match ? WAIT : SKIP;
        shift_d = '0;
      end else if ((state_q != IDLE) && (bit_cnt_q == MAX_CNT - 6'd1)) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        case (state_q)
          WAIT: begin
            shift_d = {shift_q[AUDIO_W-2:0], sd_s};
            state_d = SHIFT;
          end
          SHIFT: begin
            shift_d = {shift_q[AUDIO_W-2:0], sd_s};
            if (bit_cnt_q == 6'd7) begin
              state_d = SKIP;
              valid_d = 1'b1;
              audio_d = to_offset_binary(shift_d);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Outputs come straight from flops so they are glitch-free and clear on reset.
  always_comb begin
    audio_out    = audio_q;
    sample_valid = valid_q;
    frame_err    = err_q;
  end

endmodule

// File: tb/tb_team_06_i2s_rx.sv
// Bench for team_06_i2s_rx: one left-channel and one right-channel receiver share an I2S stream.
module tb_team_06_i2s_rx;

  localparam int SCK_HALF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       i2s_sck;
  logic       i2s_ws;
  logic       i2s_sd;
  logic       last_bit;
  logic [7:0] audio_l, audio_r;
  logic       valid_l, valid_r, err_l, err_r;

  int checks    = 0;
  int failures  = 0;
  int err_cnt_l = 0;
  int err_cnt_r = 0;
  int e0_l, e0_r;

  logic [7:0] exp_q_l[$];
  logic [7:0] exp_q_r[$];

  // 100 MHz-style system clock; SCK is derived from it at 1/16.
  always #5 clk = ~clk;

  team_06_i2s_rx #(.CHANNEL(0), .MAX_SLOT_BITS(32)) dut_l (
    .clk(clk), .rst(rst), .en(en),
    .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
    .audio_out(audio_l), .sample_valid(valid_l), .frame_err(err_l)
  );

  team_06_i2s_rx #(.CHANNEL(1), .MAX_SLOT_BITS(32)) dut_r (
    .clk(clk), .rst(rst), .en(en),
    .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .i2s_sd(i2s_sd),
    .audio_out(audio_r), .sample_valid(valid_r), .frame_err(err_r)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [7:0] expect_sample(input logic [31:0] word);
    return {~word[31], word[30:24]};
  endfunction

  // Sends one slot of nbits SCK periods; the first period carries the previous slot's last bit.
  task automatic applyStimulus(input logic ws, input logic [31:0] word, input int nbits, input bit capture);
    if (capture) begin
      if (ws) exp_q_r.push_back(expect_sample(word));
      else    exp_q_l.push_back(expect_sample(word));
    end
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      i2s_sck = 1'b0;
      i2s_ws  = ws;
      if (i == 0)       i2s_sd = last_bit;
      else if (i < 32)  i2s_sd = word[32-i];
      else              i2s_sd = 1'b0;
      repeat (SCK_HALF) @(negedge clk);
      i2s_sck = 1'b1;
      repeat (SCK_HALF - 1) @(negedge clk);
    end
    last_bit = (nbits <= 32) ? word[32-nbits] : 1'b0;
  endtask

  task automatic sendFrame(input logic [31:0] left, input logic [31:0] right, input bit cap_l, input bit cap_r);
    applyStimulus(1'b0, left, 32, cap_l);
    applyStimulus(1'b1, right, 32, cap_r);
  endtask

  // Every strobe is matched against the oldest expected sample for that receiver.
  always @(negedge clk) begin
    if (valid_l | err_l) checkOutput("excl_l", {31'b0, valid_l & err_l}, 32'd0);
    if (valid_r | err_r) checkOutput("excl_r", {31'b0, valid_r & err_r}, 32'd0);
    if (err_l) err_cnt_l++;
    if (err_r) err_cnt_r++;
    if (valid_l) begin
      checkOutput("valid_expected_l", {31'b0, exp_q_l.size() != 0}, 32'd1);
      if (exp_q_l.size() != 0) checkOutput("sample_l", {24'b0, audio_l}, {24'b0, exp_q_l.pop_front()});
    end
    if (valid_r) begin
      checkOutput("valid_expected_r", {31'b0, exp_q_r.size() != 0}, 32'd1);
      if (exp_q_r.size() != 0) checkOutput("sample_r", {24'b0, audio_r}, {24'b0, exp_q_r.pop_front()});
    end
  end

  // Guards against a stalled run.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main scenario sequence.
  initial begin
    rst = 1'b1; en = 1'b1; i2s_sck = 1'b0; i2s_ws = 1'b0; i2s_sd = 1'b0; last_bit = 1'b0;
    #1;
    checkOutput("reset_audio_l", {24'b0, audio_l}, 32'd128);
    checkOutput("reset_audio_r", {24'b0, audio_r}, 32'd128);
    checkOutput("reset_valid_l", {31'b0, valid_l}, 32'd0);
    checkOutput("reset_err_l", {31'b0, err_l}, 32'd0);
    repeat (4) @(negedge clk);
    rst = 1'b0;

    applyStimulus(1'b0, 32'h0, 4, 1'b0);
    applyStimulus(1'b1, 32'hA500_0000, 32, 1'b1);

    sendFrame(32'h7F12_3456, 32'h3355_AA00, 1'b1, 1'b1);
    checkOutput("left_7f", {24'b0, audio_l}, 32'hFF);
    sendFrame(32'h80FF_FFFF, 32'h0101_0101, 1'b1, 1'b1);
    checkOutput("left_80", {24'b0, audio_l}, 32'h00);
    sendFrame(32'h00AB_CDEF, 32'hFFFF_0000, 1'b1, 1'b1);
    checkOutput("left_00", {24'b0, audio_l}, 32'h80);
    sendFrame(32'h1234_5678, 32'hC3C3_C3C3, 1'b1, 1'b1);
    checkOutput("right_c3", {24'b0, audio_r}, 32'h43);
    checkOutput("left_12", {24'b0, audio_l}, 32'h92);

    e0_l = err_cnt_l; e0_r = err_cnt_r;
    applyStimulus(1'b0, 32'hAB00_0000, 5, 1'b0);
    applyStimulus(1'b1, 32'h4400_0000, 32, 1'b1);
    checkOutput("short_err_l", err_cnt_l - e0_l, 32'd1);
    checkOutput("short_err_r", err_cnt_r - e0_r, 32'd0);
    checkOutput("short_hold_l", {24'b0, audio_l}, 32'h92);
    sendFrame(32'h7E00_0000, 32'h0F00_0000, 1'b1, 1'b1);
    checkOutput("short_recover_l", {24'b0, audio_l}, 32'hFE);

    e0_l = err_cnt_l; e0_r = err_cnt_r;
    applyStimulus(1'b0, 32'h3C00_0000, 40, 1'b1);
    checkOutput("stuck_err_l", err_cnt_l - e0_l, 32'd1);
    checkOutput("stuck_err_r", err_cnt_r - e0_r, 32'd1);
    applyStimulus(1'b1, 32'h2200_0000, 32, 1'b1);
    applyStimulus(1'b0, 32'h6000_0000, 32, 1'b1);
    checkOutput("stuck_recover_l", {24'b0, audio_l}, 32'hE0);
    checkOutput("stuck_once_l", err_cnt_l - e0_l, 32'd1);
    applyStimulus(1'b1, 32'h1100_0000, 32, 1'b1);

    fork
      applyStimulus(1'b0, 32'h0100_0000, 32, 1'b1);
      begin
        repeat (250) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_audio_l", {24'b0, audio_l}, 32'd128);
        checkOutput("rst_audio_r", {24'b0, audio_r}, 32'd128);
        checkOutput("rst_valid_l", {31'b0, valid_l}, 32'd0);
        checkOutput("rst_err_r", {31'b0, err_r}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    applyStimulus(1'b1, 32'h9A00_0000, 32, 1'b1);
    checkOutput("post_rst_hold_l", {24'b0, audio_l}, 32'd128);
    applyStimulus(1'b0, 32'h5500_0000, 32, 1'b1);
    checkOutput("rst_recover_l", {24'b0, audio_l}, 32'hD5);
    applyStimulus(1'b1, 32'h7000_0000, 32, 1'b1);

    en = 1'b0;
    repeat (3) sendFrame(32'hFF00_0000, 32'h0000_0000, 1'b0, 1'b0);
    checkOutput("en_hold_l", {24'b0, audio_l}, 32'hD5);
    checkOutput("en_hold_r", {24'b0, audio_r}, 32'hF0);
    en = 1'b1;
    sendFrame(32'h4000_0000, 32'hB000_0000, 1'b1, 1'b1);
    checkOutput("en_resume_l", {24'b0, audio_l}, 32'hC0);
    checkOutput("en_resume_r", {24'b0, audio_r}, 32'h30);

    repeat (20) @(negedge clk);
    checkOutput("sb_empty_l", exp_q_l.size(), 32'd0);
    checkOutput("sb_empty_r", exp_q_r.size(), 32'd0);
    checkOutput("err_total_l", err_cnt_l, 32'd2);
    checkOutput("err_total_r", err_cnt_r, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
